// File: rtl/instr_register_pkg.sv
// Shared types for the instruction-register store: operands, opcodes,
// store addresses and the packed instruction word.
package instr_register_pkg;

   typedef logic signed [31:0] operand_t;

   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;

   typedef logic [4:0] address_t;

   typedef struct packed {
      opcode_t            opc;
      operand_t           op_a;
      operand_t           op_b;
      logic signed [63:0] result;
   } instruction_t;

endpackage

// File: rtl/instr_register_exec.sv
// 32-entry instruction store with single-cycle ALU ops and an iterative signed DIV/MOD unit.
// Optional macro ENTRY_VALID_EN adds per-entry valid bits and the read_valid output.
module instr_register_exec
   import instr_register_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int DIV_ITER = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   output logic               load_ready,
   input  logic [4:0]         write_pointer,
   input  logic [2:0]         opcode,
   input  logic signed [31:0] operand_a,
   input  logic signed [31:0] operand_b,
   input  logic [4:0]         read_pointer,
   output instruction_t       instruction_word,
`ifdef ENTRY_VALID_EN
   output logic               read_valid,
`endif
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
   localparam int CNT_W = $clog2(DIV_ITER);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [32:0]        rem_q, rem_d;
   logic [31:0]        quo_q, quo_d;
   logic [31:0]        dvsr_q, dvsr_d;
   address_t           addr_q, addr_d;
   opcode_t            opc_q, opc_d;
   operand_t           a_q, a_d;
   operand_t           b_q, b_d;

   instruction_t       store_q [DEPTH];
   instruction_t       instr_word_q;

   opcode_t            opc_in;
   logic               accept;
   logic signed [63:0] a64, b64, alu_res;
   logic [31:0]        abs_a, abs_b;
   logic [32:0]        rem_sh, diff;
   logic [32:0]        q_s, r_s;
   logic signed [63:0] div_res;
   logic               wr_en;
   address_t           wr_addr;
   instruction_t       wr_data;

   assign load_ready       = (state_q == IDLE);
   assign busy             = !load_ready;
   assign instruction_word = instr_word_q;

   assign opc_in = opcode_t'(opcode);
   assign accept = load_en && load_ready;
   assign a64    = {{32{operand_a[31]}}, operand_a};
   assign b64    = {{32{operand_b[31]}}, operand_b};
   assign abs_a  = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
   assign abs_b  = operand_b[31] ? (~operand_b + 32'd1) : operand_b;

   // Restoring step: partial remainder pulls in the next dividend bit from the top of quo_q.
   assign rem_sh = {rem_q[31:0], quo_q[31]};
   assign diff   = rem_sh - {1'b0, dvsr_q};

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign q_s     = (a_q[31] ^ b_q[31]) ? -{1'b0, quo_q} : {1'b0, quo_q};
   assign r_s     = a_q[31] ? -{1'b0, rem_q[31:0]} : {1'b0, rem_q[31:0]};
   assign div_res = (b_q == 32'sd0) ? 64'sd0 :
                    (opc_q == DIV)  ? {{31{q_s[32]}}, q_s} : {{31{r_s[32]}}, r_s};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_res = '0;
      case (opc_in)
         PASSA:   alu_res = a64;
         PASSB:   alu_res = b64;
         ADD:     alu_res = a64 + b64;
         SUB:     alu_res = a64 - b64;
         MULT:    alu_res = a64 * b64;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      addr_d  = addr_q;
      opc_d   = opc_q;
      a_d     = a_q;
      b_d     = b_q;
      wr_en   = 1'b0;
      wr_addr = write_pointer;
      wr_data = '{opc: opc_in, op_a: operand_a, op_b: operand_b, result: alu_res};

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (opc_in == DIV || opc_in == MOD) begin
                  addr_d  = write_pointer;
                  opc_d   = opc_in;
                  a_d     = operand_a;
                  b_d     = operand_b;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = abs_a;
                  dvsr_d  = abs_b;
                  state_d = (operand_b == 32'sd0) ? DIV_DONE : DIV_RUN;
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         DIV_RUN: begin
            if (diff[32]) begin
               rem_d = rem_sh;
               quo_d = {quo_q[30:0], 1'b0};
            end else begin
               rem_d = diff;
               quo_d = {quo_q[30:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
            wr_data = '{opc: opc_q, op_a: a_q, op_b: b_q, result: div_res};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         addr_q  <= '0;
         opc_q   <= ZERO;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         addr_q  <= addr_d;
         opc_q   <= opc_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   // NOTE: the store is reset entry-by-entry because cleared contents are architecturally visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
         instr_word_q <= '0;
      end else begin
         if (wr_en) store_q[wr_addr] <= wr_data;
         instr_word_q <= store_q[read_pointer];
      end
   end

`ifdef ENTRY_VALID_EN
   logic [DEPTH-1:0] valid_q;
   logic             read_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= '0;
         read_valid_q <= 1'b0;
      end else begin
         if (wr_en) valid_q[wr_addr] <= 1'b1;
         read_valid_q <= valid_q[read_pointer];
      end
   end

   assign read_valid = read_valid_q;
`endif

endmodule

// File: doc/instr_register_exec.md
Name: instr_register_exec

Overview:
- Instruction register store with execution, sitting on the bench-facing instruction-register interface.
- Accepts opcode/operand writes into a 32-entry store, computes the 64-bit result, and returns the full instruction word on reads.
- Single-cycle ops complete at the write edge; DIV/MOD run on a shared iterative divider with a ready/busy handshake.
- Types come from instr_register_pkg: operand_t is signed 32-bit, opcode_t is 3-bit (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), address_t is 5-bit, instruction_t is {opc, op_a, op_b, result[63:0]}.

Parameters:
- DEPTH, 32, number of entries; must equal 2**$bits(address_t).
- DIV_ITER, 32, divider iterations; must equal operand width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write request.
- load_ready  output  1  write accepted this cycle when load_en && load_ready.
- write_pointer  input  5  entry to write.
- opcode  input  3  opcode_t of the write.
- operand_a  input  32  signed operand A.
- operand_b  input  32  signed operand B.
- read_pointer  input  5  entry to read.
- instruction_word  output  instruction_t  registered read data.
- busy  output  1  divider FSM not IDLE; equals !load_ready.

Behaviour:
- Reset, async assert/deassert on clk domain:
  - every entry = {ZERO, 0, 0, 0}; instruction_word = 0.
  - FSM = IDLE; load_ready = 1; busy = 0.
  - a reset during a divide aborts it; the pending entry is not written.
- Read path:
  - instruction_word <= store[read_pointer] every edge; latency 1 cycle.
  - Read and write of the same address on the same edge returns the old contents (read-before-write).
- Write acceptance: load_en && load_ready at a rising edge. While load_ready = 0, load_en is ignored; the write is dropped, not queued.
- Single-cycle ops write {opc, op_a, op_b, result} at the accept edge:
  - ZERO: 0.
  - PASSA / PASSB: operand sign-extended to 64.
  - ADD / SUB: 33-bit signed result sign-extended to 64; no overflow loss.
  - MULT: full 64-bit signed product.
- DIV/MOD FSM, states IDLE, DIV_RUN, DIV_DONE:
  - IDLE -> DIV_RUN on accepted DIV/MOD with operand_b != 0. Latch address, opcode, operands, |a|, |b| and signs; iter counter = 0; load_ready drops after this edge.
  - DIV_RUN: one restoring shift-subtract step per cycle. When counter == DIV_ITER-1, go to DIV_DONE.
  - DIV_DONE: apply signs and write the entry, then go to IDLE.
    - Quotient truncates toward zero; remainder takes the sign of the dividend (SystemVerilog semantics).
    - Result is sign-extended to 64.
  - IDLE -> DIV_DONE directly when operand_b == 0; result = 0 for both DIV and MOD.
  - Accept edge E0; entry written at edge E0+DIV_ITER+1 (E33); load_ready high again after E33. Divide by zero: written at E1.
- load_ready = (state == IDLE), combinational from state register.
- Entries not being written keep their value; wrap-around is not applicable (address is explicit).

Optional Feature:
- Macro ENTRY_VALID_EN.
- When defined:
  - adds per-entry valid bit (reset 0, set when the entry is written) and output port read_valid, 1 bit, registered alongside instruction_word with the same 1-cycle latency.
  - aborted divides do not set valid.
- When undefined: no valid storage and no read_valid port; all other behaviour identical.

Test Plan:
- Reset then read addr 0..31 -> instruction_word == 0 each cycle, load_ready == 1, busy == 0.
- Write addr 3 ADD a=-7 b=5; read 3 next cycle -> opc=ADD, op_a=-7, op_b=5, result=-2 (64-bit sign-extended). Write addr 4 MULT a=-15 b=15 -> result=-225.
- Write addr 9 DIV a=-13 b=4 -> load_ready low for exactly 33 cycles, load_en pulses during busy dropped; read 9 -> result=-3. MOD same operands at addr 10 -> result=-1.
- DIV a=12 b=0 at addr 5 -> load_ready low 1 cycle, result=0; MOD a=12 b=0 -> result=0.
- Same-edge write/read addr 7 (old PASSA a=2, new PASSB b=9) -> read returns old word (result=2), next read returns 9.
- Assert reset at cycle 10 of a DIV into addr 12 -> entry 12 stays 0, load_ready=1 after reset; with ENTRY_VALID_EN, read_valid for 12 == 0 and for a completed write == 1.
